// File: rtl/mutex_buf_pkg.sv
// mutex_buf_pkg: shared limits and widths for the mutex buffer manager
package mutex_buf_pkg;
  localparam int C_MAX_READER_NUM = 6;
  localparam int C_DROP_CNT_W = 16;
endpackage

// File: rtl/mutex_buf_pick_free.sv
// mutex_buf_pick_free: lowest clear bit of a busy mask as one-hot and index
module mutex_buf_pick_free #(
  parameter int N = 4
) (
  input  logic [N-1:0]         mask,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  assign onehot = ~mask & (mask + N'(1));
  assign found = |onehot;
  // encode the one-hot free bit as a binary index
  always_comb begin
    idx = '0;
    for (int k = 0; k < N; k++) idx = onehot[k] ? ($clog2(N))'(k) : idx;
  end
endmodule

// File: rtl/mutex_buffer_mgr.sv
// mutex_buffer_mgr: writer/reader buffer ownership manager; MUTEX_BUF_DROP_CNT_EN adds drop_cnt
module mutex_buffer_mgr
  import mutex_buf_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_READER_NUM = 2,
  localparam int C_BUFF_NUM = C_READER_NUM + 2,
  localparam int C_IDX_W = $clog2(C_BUFF_NUM)
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [C_BUFF_NUM*C_ADDR_WIDTH-1:0] buf_addr,
  input  logic                               w_sof,
  output logic [C_ADDR_WIDTH-1:0]            w_addr,
  output logic [C_IDX_W-1:0]                 w_idx,
  output logic                               w_valid,
  input  logic [C_READER_NUM-1:0]            r_sof,
  output logic [C_READER_NUM*C_ADDR_WIDTH-1:0] r_addr,
  output logic [C_READER_NUM-1:0]            r_valid,
  output logic                               intr
`ifdef MUTEX_BUF_DROP_CNT_EN
  ,output logic [C_DROP_CNT_W-1:0]           drop_cnt
`endif
);
  if (C_READER_NUM < 1 || C_READER_NUM > C_MAX_READER_NUM) begin : g_bad_reader_num
    $error("mutex_buffer_mgr: C_READER_NUM must be 1..%0d", C_MAX_READER_NUM);
  end
  logic [C_BUFF_NUM-1:0]   w_bmp, last_bmp, mask, free_oh;
  logic [C_BUFF_NUM-1:0]   r_bmp [C_READER_NUM];
  logic [C_ADDR_WIDTH-1:0] r_addr_q [C_READER_NUM];
  logic [C_ADDR_WIDTH-1:0] last_addr, free_addr;
  logic [C_IDX_W-1:0]      free_idx;
  logic                    free_found, last_valid, publish;
  assign publish = w_sof & w_valid;
  assign free_addr = buf_addr[free_idx*C_ADDR_WIDTH +: C_ADDR_WIDTH];
  // busy mask: writer plus every reader
  always_comb begin
    mask = w_bmp;
    for (int i = 0; i < C_READER_NUM; i++) mask = mask | r_bmp[i];
  end
  mutex_buf_pick_free #(.N(C_BUFF_NUM)) u_pick (
    .mask   (mask),
    .onehot (free_oh),
    .idx    (free_idx),
    .found  (free_found)
  );
  // writer grabs the lowest free buffer and publishes the previous one as last
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_bmp <= '0;
      w_addr <= '0;
      w_idx <= '0;
      w_valid <= 1'b0;
      last_bmp <= '0;
      last_addr <= '0;
      last_valid <= 1'b0;
      intr <= 1'b0;
    end else begin
      intr <= publish;
      if (w_sof) begin
        w_bmp <= free_oh;
        w_valid <= free_found;
        w_addr <= free_found ? free_addr : w_addr;
        w_idx <= free_found ? free_idx : w_idx;
      end
      if (publish) begin
        last_bmp <= w_bmp;
        last_addr <= w_addr;
        last_valid <= 1'b1;
      end
    end
  end
  // each reader takes the frame being published, else the last published one
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < C_READER_NUM; i++) begin
        r_bmp[i] <= '0;
        r_addr_q[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      for (int i = 0; i < C_READER_NUM; i++) begin
        if (r_sof[i]) begin
          r_bmp[i] <= publish ? w_bmp : last_bmp;
          r_addr_q[i] <= publish ? w_addr : last_addr;
          r_valid[i] <= publish | last_valid;
        end
      end
    end
  end
  for (genvar g = 0; g < C_READER_NUM; g++) begin : g_r_addr
    assign r_addr[g*C_ADDR_WIDTH +: C_ADDR_WIDTH] = r_addr_q[g];
  end
`ifdef MUTEX_BUF_DROP_CNT_EN
  logic last_taken;
  // count published frames replaced before any reader picked them up
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_taken <= 1'b0;
      drop_cnt <= '0;
    end else begin
      last_taken <= |r_sof ? 1'b1 : publish ? 1'b0 : last_taken;
      if (publish && last_valid && !last_taken && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: doc/mutex_buffer_mgr.md
MUTEX_BUFFER_MGR -- requirements
Module: mutex_buffer_mgr

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 32, buffer address width.
REQ-002 SHALL have parameter C_READER_NUM, default 2, reader count; legal range 1..6; other values SHALL fail elaboration.
REQ-003 SHALL have localparam C_BUFF_NUM = C_READER_NUM+2, buffer count.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 buf_addr  in  C_BUFF_NUM*C_ADDR_WIDTH  buffer base addresses; slice k = buffer k.
REQ-007 w_sof  in  1  writer start-of-frame pulse.
REQ-008 w_addr  out  C_ADDR_WIDTH  buffer the writer fills.
REQ-009 w_idx  out  $clog2(C_BUFF_NUM)  index of w_addr buffer.
REQ-010 w_valid  out  1  writer owns a buffer.
REQ-011 r_sof  in  C_READER_NUM  per-reader start-of-frame pulses.
REQ-012 r_addr  out  C_READER_NUM*C_ADDR_WIDTH  per-reader buffer address.
REQ-013 r_valid  out  C_READER_NUM  reader holds a completed frame.
REQ-014 intr  out  1  frame-published pulse.
REQ-015 drop_cnt  out  16  dropped-frame count (present only per REQ-031).

Function
REQ-016 Ownership SHALL be one-hot bitmaps: w_bmp, last_bmp, r_bmp[i], each C_BUFF_NUM wide.
REQ-017 On w_sof, writer SHALL take lowest index k with bit k clear in mask = w_bmp | OR of all r_bmp (pre-edge values); w_addr=slice k, w_idx=k, w_valid=1, latency 1 cycle.
REQ-018 Mask has at most C_READER_NUM+1 bits set, so a free buffer always exists; no-free case SHALL be unreachable and, if reached, set w_bmp=0, w_valid=0.
REQ-019 On w_sof with w_valid=1, last (addr, bmp, valid) SHALL load current writer state; with w_valid=0, last SHALL hold.
REQ-020 On r_sof[i] with w_sof and w_valid=1, reader i SHALL load current writer addr/bmp, r_valid[i]=1.
REQ-021 On r_sof[i] otherwise, reader i SHALL load last addr/bmp/valid (r_valid[i]=0 if nothing published).
REQ-022 Readers without r_sof SHALL hold; multiple simultaneous r_sof SHALL each follow REQ-020/021 independently.
REQ-023 intr SHALL be a registered 1-cycle pulse in the cycle after a w_sof with w_valid=1.
REQ-024 A reader's prior buffer SHALL be released on its r_sof edge (new bitmap replaces old).

Reset
REQ-025 On resetn=0: w_addr, w_idx, r_addr, last addr =0; all bitmaps =0; w_valid, r_valid, last valid, intr =0; drop_cnt=0.
REQ-026 Reset SHALL override coincident w_sof/r_sof; reset mid-frame discards all ownership.

Configuration
REQ-027 Macro MUTEX_BUF_DROP_CNT_EN SHALL gate the drop counter.
REQ-028 With macro: last_taken flag SHALL set when any reader loads last, or loads the writer frame coincident with its publication; SHALL clear on publication otherwise.
REQ-029 With macro: on publication while last valid and last_taken=0, drop_cnt SHALL increment by 1, saturating at 0xFFFF.
REQ-030 A reader taking the new writer frame on w_sof SHALL NOT count as taking the old last.
REQ-031 Without macro: drop_cnt port and flag SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package mutex_buf_pkg SHALL hold C_MAX_READER_NUM=6 and the drop_cnt width constant 16.
REQ-033 Lowest-free-bit selection SHALL be sub-module mutex_buf_pick_free (mask in; one-hot, index, found out; combinational).

Verification (C_READER_NUM=2, buf_addr = 0x1000/0x2000/0x3000/0x4000)
REQ-034 Reset, w_sof -> next cycle w_addr=0x1000, w_idx=0, w_valid=1, intr=0, r_valid=00.
REQ-035 Second w_sof -> w_addr=0x2000, intr=1 one cycle later; then r_sof[0] -> r_addr[0]=0x1000, r_valid[0]=1; third w_sof -> w_addr=0x3000.
REQ-036 r0=buf0, r1=buf1, writer buf2: w_sof -> buf3 (0x4000); next w_sof -> buf2 (0x3000).
REQ-037 w_sof and r_sof[1] same cycle with writer 0x3000 -> r_addr[1]=0x3000, r_valid[1]=1.
REQ-038 Macro on: four w_sof with no r_sof -> drop_cnt=2; resetn low mid-stream -> all outputs zero next cycle.
